bist_lfsr_misr_ctrl: RTL
========================

// Module: bist_lfsr_misr_ctrl
// PURPOSE
//  Parametrised self-test engine for the pixel pipeline: generates N pseudo-random pixels from a seeded LFSR.
//  Feeds them to the gray/sobel core with a px_rdy-style strobe and compacts every core output into a MISR.
//  Compares the final signature against a golden value. Successor to the fixed 8-bit LFSR + signature_analyzer pair.
//  Adds: widths, pattern/response counts, issue pacing, golden compare, optional watchdog. Sits between spi_control and top_gray_sobel.
// PARAMETERS
//  DATA_W       8      pattern (input pixel) width, >=2
//  RESP_W       8      response (output pixel) / signature width, >=2
//  CNT_W        16     width of pattern and response counters
//  LFSR_POLY    8'hB8  LFSR tap mask, DATA_W bits
//  MISR_POLY    8'hB8  MISR tap mask, RESP_W bits
//  ISSUE_GAP    2      idle cycles between consecutive pattern strobes (0 = back-to-back)
//  TIMEOUT_CYC  255    watchdog limit in cycles (only with BIST_TIMEOUT_EN)
// PORTS
//  clk_i         in   1       clock
//  reset_i       in   1       synchronous, active-high reset
//  start_i       in   1       level; sampled only in IDLE/DONE, starts a run
//  seed_i        in   DATA_W  LFSR seed, captured on start
//  num_pat_i     in   CNT_W   patterns to issue, captured on start
//  num_resp_i    in   CNT_W   responses expected, captured on start
//  golden_i      in   RESP_W  expected signature, sampled in DONE
//  pat_o         out  DATA_W  current pattern, valid while pat_rdy_o=1
//  pat_rdy_o     out  1       one-cycle pattern strobe
//  resp_i        in   RESP_W  core output pixel
//  resp_rdy_i    in   1       one-cycle response strobe
//  signature_o   out  RESP_W  live MISR contents
//  busy_o        out  1       run in progress
//  done_o        out  1       high in DONE until next start or reset
//  pass_o        out  1       done_o & (signature_o==golden_i) & ~timeout_o
//  timeout_o     out  1       watchdog expired in the current run
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, LFSR=1, MISR=0, counters=0.
//  FSM IDLE -> RUN on start_i; RUN -> DONE when issued==num_pat & received==num_resp (or watchdog); DONE -> RUN on start_i.
//  Start, one cycle: latch counts; MISR<=0; LFSR<=seed_i, or 1 if seed_i==0; clear counters and timeout_o; busy_o=1 next cycle.
//  Issue, in RUN while issued<num_pat:
//   - first strobe on 1st RUN cycle; then one strobe every ISSUE_GAP+1 cycles.
//   - pat_o = LFSR value; LFSR steps on the strobe cycle: lfsr <= {lfsr[DATA_W-2:0], ^(lfsr & LFSR_POLY)}.
//  Capture, in RUN while received<num_resp: on resp_rdy_i, sig <= {sig[RESP_W-2:0], ^(sig & MISR_POLY)} ^ resp_i; received++.
//  resp_rdy_i outside RUN, or beyond num_resp: ignored, MISR frozen.
//  Issue and capture are independent, may coincide; pat_rdy_o and a response in the same cycle are both honoured.
//  num_pat=0: no strobes. num_pat=0 & num_resp=0: DONE one cycle after start.
//  DONE: busy_o=0, done_o=1; pass_o combinational on golden_i. start_i while RUN ignored; reset mid-run aborts immediately to reset values.
//  Counters never wrap: saturate at the latched target.
// CONFIGURATION
//  BIST_TIMEOUT_EN defined:
//   - watchdog counts RUN cycles since the last resp_rdy_i (or since start); cleared by any accepted response.
//   - reaching TIMEOUT_CYC: timeout_o=1, go to DONE, pass_o=0.
//  Not defined: no watchdog, RUN waits indefinitely, timeout_o tied 0.
// STRUCTURE
//  bist_pkg: state enum (IDLE, RUN, DONE), default LFSR/MISR polys, step functions lfsr_next()/misr_next().
//  Sub-module bist_misr (RESP_W, MISR_POLY): clear, en, data -> signature.
//  LFSR, counters, pacing and FSM stay in this module.
// TESTING
//  seed=0, num_pat=3, num_resp=0, GAP=2 -> pat_o 01,02,04 at cycles 1,4,7 after start; done_o one cycle after 3rd strobe.
//  num_resp=2, resp 01 then 00, golden=02 -> signature_o 01 then 02; done_o=1, pass_o=1; golden=03 -> pass_o=0.
//  3 resp_rdy_i with num_resp=2 -> 3rd ignored, signature stays 02; response coincident with strobe -> both counted.
//  reset_i pulse mid-RUN after 1 pattern -> next cycle all outputs 0; restart reproduces first pattern 01.
//  BIST_TIMEOUT_EN, TIMEOUT_CYC=10, num_resp=1, no response -> timeout_o=1, done_o=1, pass_o=0 at cycle 10; undefined -> busy_o stays 1.
//  start_i held during RUN -> no restart; held through DONE -> new run, MISR cleared to 00.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and step functions for the LFSR/MISR self-test engine.
// Step functions work on up to 32-bit registers; callers zero-extend and truncate.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] DEF_LFSR_POLY = 8'hB8;
    localparam logic [7:0] DEF_MISR_POLY = 8'hB8;

    function automatic logic [31:0] width_mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Shift left, feeding back the parity of the tapped bits into bit 0.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v, input logic [31:0] poly,
                                              input int w);
        return {v[30:0], ^(v & poly)} & width_mask(w);
    endfunction

    function automatic logic [31:0] misr_next(input logic [31:0] v, input logic [31:0] poly,
                                              input logic [31:0] d, input int w);
        return lfsr_next(v, poly, w) ^ (d & width_mask(w));
    endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: compacts one response word per enabled cycle.
module bist_misr
    import bist_pkg::*;
#(
    parameter int                RESP_W    = 8,
    parameter logic [RESP_W-1:0] MISR_POLY = RESP_W'(DEF_MISR_POLY)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [RESP_W-1:0] data_i,
    output logic [RESP_W-1:0] sig_o
);

    logic [RESP_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = RESP_W'(misr_next(32'(sig_q), 32'(MISR_POLY), 32'(data_i), RESP_W));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) sig_q <= '0;
        else         sig_q <= sig_d;
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/bist_lfsr_misr_ctrl.sv
// Self-test engine: seeded LFSR pattern issue with pacing, MISR response compaction, golden compare.
// Optional watchdog enabled by defining BIST_TIMEOUT_EN.
module bist_lfsr_misr_ctrl
    import bist_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                RESP_W      = 8,
    parameter int                CNT_W       = 16,
    parameter logic [DATA_W-1:0] LFSR_POLY   = DATA_W'(DEF_LFSR_POLY),
    parameter logic [RESP_W-1:0] MISR_POLY   = RESP_W'(DEF_MISR_POLY),
    parameter int                ISSUE_GAP   = 2,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic [CNT_W-1:0]  num_pat_i,
    input  logic [CNT_W-1:0]  num_resp_i,
    input  logic [RESP_W-1:0] golden_i,
    output logic [DATA_W-1:0] pat_o,
    output logic              pat_rdy_o,
    input  logic [RESP_W-1:0] resp_i,
    input  logic              resp_rdy_i,
    output logic [RESP_W-1:0] signature_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o
);

    localparam int GAP_W = $clog2(ISSUE_GAP + 2);

    if ((DATA_W < 2) || (DATA_W > 32) || (RESP_W < 2) || (RESP_W > 32) || (TIMEOUT_CYC < 1))
    begin : g_bad_param
        $error("bist_lfsr_misr_ctrl: unsupported parameter combination");
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  issued_q, issued_d, received_q, received_d;
    logic [CNT_W-1:0]  num_pat_q, num_pat_d, num_resp_q, num_resp_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              running, strobe, resp_acc, misr_clr;

`ifdef BIST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 2);
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        issued_d   = issued_q;
        received_d = received_q;
        num_pat_d  = num_pat_q;
        num_resp_d = num_resp_q;
        gap_d      = gap_q;
        misr_clr   = 1'b0;
`ifdef BIST_TIMEOUT_EN
        wd_d       = wd_q;
        timeout_d  = timeout_q;
`endif
        running  = (state_q == RUN);
        strobe   = running && (issued_q < num_pat_q) && (gap_q == '0);
        resp_acc = running && resp_rdy_i && (received_q < num_resp_q);

        if (strobe) begin
            lfsr_d   = DATA_W'(lfsr_next(32'(lfsr_q), 32'(LFSR_POLY), DATA_W));
            issued_d = issued_q + CNT_W'(1);
            gap_d    = GAP_W'(ISSUE_GAP);
        end else if (running && (gap_q != '0)) begin
            gap_d = gap_q - GAP_W'(1);
        end
        if (resp_acc) received_d = received_q + CNT_W'(1);

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d    = RUN;
                    num_pat_d  = num_pat_i;
                    num_resp_d = num_resp_i;
                    lfsr_d     = (seed_i == '0) ? DATA_W'(1) : seed_i;
                    issued_d   = '0;
                    received_d = '0;
                    gap_d      = '0;
                    misr_clr   = 1'b1;
`ifdef BIST_TIMEOUT_EN
                    // The start cycle itself counts toward the watchdog budget.
                    wd_d       = WD_W'(1);
                    timeout_d  = 1'b0;
`endif
                end
            end
            RUN: begin
`ifdef BIST_TIMEOUT_EN
                wd_d = resp_acc ? '0 : wd_q + WD_W'(1);
`endif
                // Look at next-cycle counts so DONE follows the final event by one cycle.
                if ((issued_d == num_pat_q) && (received_d == num_resp_q)) begin
                    state_d = DONE;
                end
`ifdef BIST_TIMEOUT_EN
                else if (!resp_acc && ((wd_q + WD_W'(1)) >= WD_W'(TIMEOUT_CYC))) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            lfsr_q     <= DATA_W'(1);
            issued_q   <= '0;
            received_q <= '0;
            num_pat_q  <= '0;
            num_resp_q <= '0;
            gap_q      <= '0;
`ifdef BIST_TIMEOUT_EN
            wd_q       <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            num_pat_q  <= num_pat_d;
            num_resp_q <= num_resp_d;
            gap_q      <= gap_d;
`ifdef BIST_TIMEOUT_EN
            wd_q       <= wd_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    bist_misr #(
        .RESP_W   (RESP_W),
        .MISR_POLY(MISR_POLY)
    ) u_misr (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(misr_clr),
        .en_i   (resp_acc),
        .data_i (resp_i),
        .sig_o  (signature_o)
    );

`ifdef BIST_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // The reset LFSR value is 1, so gate the pattern bus to keep it quiet between strobes.
    assign pat_rdy_o = strobe;
    assign pat_o     = strobe ? lfsr_q : '0;
    assign busy_o    = running;
    assign done_o    = (state_q == DONE);
    assign pass_o    = done_o && (signature_o == golden_i) && !timeout_o;

endmodule
